sticky_flags: RTL and testbench
===============================

Name: sticky_flags

Overview:
- Parametrised bank of sticky event flags with per-flag mode, clear, mask, saturating event counters, overflow detection and a combined interrupt.
- Sits between event sources, such as FIFO error strobes, and a status/CSR block.
- Widths are always legal. Flags are removed via INCLUDE_FLAGS, never via NUM_FLAGS=0.

Parameters:
- INCLUDE_FLAGS, 1, when 0 all outputs are tied to zero, no flops are inferred, and port widths keep their parameter values.
- NUM_FLAGS, 5, number of flags. Must be >=1; elaboration fails otherwise.
- COUNT_W, 4, width of each per-flag event counter. Must be >=1; elaboration fails otherwise.
- EDGE_MODE, '0, NUM_FLAGS-bit vector. Bit i=1 means flag i triggers on the rising edge of i_events[i]; bit i=0 means it triggers on level.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_cg  input  1  clock-gate enable. 0 holds all state.
- i_events  input  NUM_FLAGS  raw event inputs, synchronous to i_clk.
- i_clear  input  NUM_FLAGS  per-flag clear strobe, one cycle, write-1-to-clear.
- i_mask  input  NUM_FLAGS  1 = flag excluded from o_irq.
- o_flags  output  NUM_FLAGS  sticky flags.
- o_overflow  output  NUM_FLAGS  flag i saw a further event while already set.
- o_count  output  NUM_FLAGS*COUNT_W  per-flag event counts, packed. Flag i occupies [i*COUNT_W +: COUNT_W].
- o_irq  output  1  registered OR of unmasked flags.

Behaviour:
- Reset (async assert, sync to i_clk on deassert):
  - o_flags=0, o_overflow=0, o_count=0, o_irq=0.
  - Edge-detect history register = 0, so an input already high at the first enabled cycle after reset counts as an edge.
- Event qualify, per flag i:
  - ev[i] = i_events[i] when EDGE_MODE[i]=0.
  - ev[i] = i_events[i] & ~prev[i] when EDGE_MODE[i]=1.
  - prev[i] <= i_events[i] every enabled cycle.
- Flag update (enabled cycle): flag_n[i] = (flag[i] & ~i_clear[i]) | ev[i].
  - Set beats clear: with clear and event in the same cycle, the flag ends at 1.
- Overflow update: ovf_n[i] = (ovf[i] & ~i_clear[i]) | (ev[i] & flag[i] & ~i_clear[i]).
  - An event in the same cycle as a clear does not raise overflow.
  - An event coinciding with the first set does not raise overflow.
- Counter update:
  - i_clear[i] with ev[i]: count=1.
  - i_clear[i] alone: count=0.
  - ev[i] alone: count+1, saturating at 2^COUNT_W-1 and never wrapping.
  - Otherwise: hold.
- Interrupt: o_irq <= |(flag_n & ~i_mask).
  - Latency is 1 cycle from event to o_flags and to o_irq together.
  - A mask change takes effect on o_irq at the next enabled edge.
- Latency: event sampled at edge N appears on o_flags, o_overflow, o_count and o_irq after edge N. No combinational input-to-output paths.
- i_cg=0: every register holds, including prev. Events, clears and mask changes in that cycle are ignored, not queued.
- Reset mid-operation: all state returns to reset values immediately (async). Pending counts are lost.
- INCLUDE_FLAGS=0: all outputs constant 0 and all inputs unused. Lint waivers for unused inputs are local to this block.

Test Plan:
- Level flag 0 (EDGE_MODE=0): i_events[0]=1 for 3 cycles, then 0 -> o_flags[0]=1 from cycle 1, o_count[0 +: 4]=3, o_overflow[0]=1 from cycle 2, o_irq=1 from cycle 1.
- Edge flag 1 (EDGE_MODE[1]=1): i_events[1] held high 4 cycles -> count=1, o_overflow[1]=0. Pulse low then high again -> count=2, o_overflow[1]=1.
- Simultaneous i_clear[2]=1 and ev[2]=1 with flag set, count=7, ovf=1 -> flag=1, count=1, ovf=0. Next cycle clear alone -> flag=0, count=0.
- Saturation, COUNT_W=2: 6 level events on flag 3 -> count sticks at 3. Assert i_mask[3]=1 with only flag 3 set -> o_irq falls to 0 one cycle later.
- i_cg=0 for 2 cycles during events and a clear -> no output changes. Assert i_rst_n=0 mid-burst -> all outputs 0 without waiting for a clock edge.
- Instance INCLUDE_FLAGS=0, NUM_FLAGS=5 with random stimulus -> o_flags=5'b0, o_count=0, o_irq=0 at all times. Instance NUM_FLAGS=1 -> 1-bit o_flags behaves as in the first scenario.

Source files
------------

// File: rtl/sticky_flags.sv
`default_nettype none
// ============================================================================
// sticky_flags : bank of sticky event flags with edge/level qualify,
//                write-1-to-clear, saturating counters, overflow and irq.
// Revision     : 1.0
// ============================================================================
module sticky_flags #(
    parameter bit                   INCLUDE_FLAGS = 1'b1,
    parameter int                   NUM_FLAGS     = 5,
    parameter int                   COUNT_W       = 4,
    parameter logic [NUM_FLAGS-1:0] EDGE_MODE     = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_cg,
    input  logic [NUM_FLAGS-1:0]           i_events,
    input  logic [NUM_FLAGS-1:0]           i_clear,
    input  logic [NUM_FLAGS-1:0]           i_mask,
    output logic [NUM_FLAGS-1:0]           o_flags,
    output logic [NUM_FLAGS-1:0]           o_overflow,
    output logic [NUM_FLAGS*COUNT_W-1:0]   o_count,
    output logic                           o_irq
);

    if (NUM_FLAGS < 1) begin : g_bad_num_flags
        $error("sticky_flags: NUM_FLAGS must be >= 1");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("sticky_flags: COUNT_W must be >= 1");
    end

    if (INCLUDE_FLAGS) begin : g_flags
        logic [NUM_FLAGS-1:0] flags_q, flags_d;
        logic [NUM_FLAGS-1:0] ovf_q, ovf_d;
        logic [NUM_FLAGS-1:0] prev_q;
        logic [NUM_FLAGS-1:0] ev;
        logic [COUNT_W-1:0]   count_q [NUM_FLAGS];
        logic [COUNT_W-1:0]   count_d [NUM_FLAGS];
        logic                 irq_q, irq_d;

        always_comb begin
            // Edge-mode flags only qualify on a 0->1 transition of the raw input.
            ev      = i_events & (~EDGE_MODE | ~prev_q);
            flags_d = (flags_q & ~i_clear) | ev;
            ovf_d   = (ovf_q & ~i_clear) | (ev & flags_q & ~i_clear);
            irq_d   = |(flags_d & ~i_mask);
            for (int i = 0; i < NUM_FLAGS; i++) begin
                count_d[i] = count_q[i];
                if (i_clear[i]) begin
                    count_d[i] = ev[i] ? COUNT_W'(1) : '0;
                end else if (ev[i] && (count_q[i] != '1)) begin
                    count_d[i] = count_q[i] + COUNT_W'(1);
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                flags_q <= '0;
                ovf_q   <= '0;
                prev_q  <= '0;
                irq_q   <= 1'b0;
                count_q <= '{default: '0};
            end else if (i_cg) begin
                flags_q <= flags_d;
                ovf_q   <= ovf_d;
                prev_q  <= i_events;
                irq_q   <= irq_d;
                count_q <= count_d;
            end
        end

        for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_pack
            assign o_count[g*COUNT_W +: COUNT_W] = count_q[g];
        end

        assign o_flags    = flags_q;
        assign o_overflow = ovf_q;
        assign o_irq      = irq_q;
    end else begin : g_none
        logic w_unused_ok;
        assign w_unused_ok = &{1'b0, i_clk, i_rst_n, i_cg, i_events, i_clear, i_mask, EDGE_MODE};

        assign o_flags    = '0;
        assign o_overflow = '0;
        assign o_count    = '0;
        assign o_irq      = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sticky_flags.sv
`default_nettype none
// ============================================================================
// tb_sticky_flags : directed self-checking bench for sticky_flags.
// Revision        : 1.0
// ============================================================================
module tb_sticky_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cg;
    logic [4:0] events, clear, mask;

    logic [4:0]  a_flags, a_ovf;
    logic [19:0] a_count;
    logic        a_irq;
    logic [4:0]  s_flags, s_ovf;
    logic [9:0]  s_count;
    logic        s_irq;
    logic [4:0]  z_flags, z_ovf;
    logic [19:0] z_count;
    logic        z_irq;
    logic [0:0]  one_flags, one_ovf;
    logic [3:0]  one_count;
    logic        one_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sticky_flags #(.INCLUDE_FLAGS(1'b1), .NUM_FLAGS(5), .COUNT_W(4), .EDGE_MODE(5'b00010)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_events(events), .i_clear(clear), .i_mask(mask),
        .o_flags(a_flags), .o_overflow(a_ovf), .o_count(a_count), .o_irq(a_irq));

    sticky_flags #(.INCLUDE_FLAGS(1'b1), .NUM_FLAGS(5), .COUNT_W(2), .EDGE_MODE(5'b00010)) u_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_events(events), .i_clear(clear), .i_mask(mask),
        .o_flags(s_flags), .o_overflow(s_ovf), .o_count(s_count), .o_irq(s_irq));

    sticky_flags #(.INCLUDE_FLAGS(1'b0), .NUM_FLAGS(5), .COUNT_W(4), .EDGE_MODE(5'b00010)) u_z (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_events(events), .i_clear(clear), .i_mask(mask),
        .o_flags(z_flags), .o_overflow(z_ovf), .o_count(z_count), .o_irq(z_irq));

    sticky_flags #(.INCLUDE_FLAGS(1'b1), .NUM_FLAGS(1), .COUNT_W(4), .EDGE_MODE(1'b0)) u_1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_events(events[0:0]), .i_clear(clear[0:0]),
        .i_mask(mask[0:0]), .o_flags(one_flags), .o_overflow(one_ovf), .o_count(one_count),
        .o_irq(one_irq));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_a(input int i);
        return 32'(a_count[i*4 +: 4]);
    endfunction

    // The flag-less instance must read zero on every cycle regardless of stimulus.
    always @(negedge clk)
        check_eq("zero_inst", 32'({z_flags, z_ovf, z_count, z_irq}), 32'h0);

    initial begin
        rst_n = 1'b0; cg = 1'b1; events = '0; clear = '0; mask = '0;
        #2;
        check_eq("rst_flags", 32'(a_flags), 32'h0);
        check_eq("rst_count", 32'(a_count), 32'h0);
        check_eq("rst_irq",   32'(a_irq),   32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Level flag 0 held for three cycles
        events = 5'b00001;
        tick();
        check_eq("lvl_flag1", 32'(a_flags), 32'h01);
        check_eq("lvl_cnt1",  cnt_a(0),     32'd1);
        check_eq("lvl_ovf1",  32'(a_ovf),   32'h0);
        check_eq("lvl_irq1",  32'(a_irq),   32'h1);
        tick();
        check_eq("lvl_ovf2",  32'(a_ovf),   32'h01);
        tick();
        events = 5'b00000;
        tick();
        check_eq("lvl_cnt3",  cnt_a(0),     32'd3);
        check_eq("lvl_flag3", 32'(a_flags), 32'h01);
        check_eq("one_flag",  32'(one_flags), 32'h1);
        check_eq("one_cnt",   32'(one_count), 32'd3);
        check_eq("one_ovf",   32'(one_ovf),   32'h1);
        check_eq("one_irq",   32'(one_irq),   32'h1);
        clear = 5'b00001;
        tick();
        clear = 5'b00000;
        check_eq("clr0_flag", 32'(a_flags), 32'h0);
        check_eq("clr0_cnt",  cnt_a(0),     32'd0);
        check_eq("clr0_ovf",  32'(a_ovf),   32'h0);
        check_eq("clr0_irq",  32'(a_irq),   32'h0);

        // Edge flag 1: a held level counts once
        events = 5'b00010;
        tick();
        check_eq("edge_flag", 32'(a_flags), 32'h02);
        repeat (3) tick();
        check_eq("edge_cnt1", cnt_a(1),     32'd1);
        check_eq("edge_ovf1", 32'(a_ovf),   32'h0);
        events = 5'b00000;
        tick();
        events = 5'b00010;
        tick();
        check_eq("edge_cnt2", cnt_a(1),     32'd2);
        check_eq("edge_ovf2", 32'(a_ovf),   32'h02);
        events = 5'b00000; clear = 5'b00010;
        tick();
        clear = 5'b00000;

        // Flag 2: set beats clear, overflow suppressed, count restarts at 1
        events = 5'b00100;
        repeat (7) tick();
        check_eq("f2_cnt7", cnt_a(2),   32'd7);
        check_eq("f2_ovf",  32'(a_ovf), 32'h04);
        clear = 5'b00100;
        tick();
        check_eq("sc_flag", 32'(a_flags), 32'h04);
        check_eq("sc_cnt",  cnt_a(2),     32'd1);
        check_eq("sc_ovf",  32'(a_ovf),   32'h0);
        events = 5'b00000;
        tick();
        clear = 5'b00000;
        check_eq("c2_flag", 32'(a_flags), 32'h0);
        check_eq("c2_cnt",  cnt_a(2),     32'd0);

        // Saturation on the 2-bit counter instance, then masking
        events = 5'b01000;
        repeat (6) tick();
        events = 5'b00000;
        check_eq("sat_cnt",   32'(s_count[7:6]), 32'd3);
        check_eq("sat_flags", 32'(s_flags),      32'h08);
        check_eq("nosat_cnt", cnt_a(3),          32'd6);
        tick();
        check_eq("sat_hold",  32'(s_count[7:6]), 32'd3);
        check_eq("irq_pre",   32'(a_irq),        32'h1);
        mask = 5'b01000;
        #1;
        check_eq("mask_lat",  32'(a_irq),        32'h1);
        tick();
        check_eq("mask_irq",  32'(a_irq),        32'h0);
        check_eq("mask_flag", 32'(a_flags),      32'h08);
        mask = 5'b00000;
        tick();
        check_eq("unmask_irq", 32'(a_irq),       32'h1);

        // Clock gate off: events, clears and mask ignored
        cg = 1'b0; events = 5'b00111; clear = 5'b01000; mask = 5'b01000;
        tick();
        tick();
        check_eq("cg_flags", 32'(a_flags), 32'h08);
        check_eq("cg_cnt3",  cnt_a(3),     32'd6);
        check_eq("cg_ovf",   32'(a_ovf),   32'h08);
        check_eq("cg_irq",   32'(a_irq),   32'h1);
        check_eq("cg_cnt0",  cnt_a(0),     32'd0);
        cg = 1'b1; events = 5'b00000; clear = 5'b00000; mask = 5'b00000;
        tick();
        check_eq("cg_resume", 32'(a_flags), 32'h08);

        // Asynchronous reset mid-burst
        events = 5'b00001;
        tick();
        check_eq("burst_flags", 32'(a_flags), 32'h09);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_flags", 32'(a_flags), 32'h0);
        check_eq("arst_count", 32'(a_count), 32'h0);
        check_eq("arst_ovf",   32'(a_ovf),   32'h0);
        check_eq("arst_irq",   32'(a_irq),   32'h0);
        check_eq("arst_one",   32'(one_flags), 32'h0);

        // Edge input already high when reset releases counts as an edge
        events = 5'b00010;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_flag", 32'(a_flags), 32'h02);
        check_eq("post_rst_cnt",  cnt_a(1),     32'd1);

        // Random traffic for the flag-less instance
        for (int k = 0; k < 20; k++) begin
            events = 5'($urandom);
            clear  = 5'($urandom);
            mask   = 5'($urandom);
            cg     = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
